// File: rtl/encoder_4_2_bh.sv
// Registered 4-to-2 priority encoder with valid and not-one-hot (err) flags.
// All outputs come from flops; nothing propagates from inputs to outputs combinationally.
module encoder_4_2_bh (
  input  logic clk,
  input  logic rst,
  input  logic i3,
  input  logic i2,
  input  logic i1,
  input  logic i0,
  output logic y1,
  output logic y0,
  output logic valid,
  output logic err
);

  logic [3:0] req;
  logic [1:0] code_d;
  logic [1:0] code_q;
  logic       valid_d;
  logic       valid_q;
  logic       err_d;
  logic       err_q;
  logic [2:0] ones_cnt;

  assign req = {i3, i2, i1, i0};

  always_comb begin
    code_d = 2'b00;
    if (req[3]) begin
      code_d = 2'b11;
    end else if (req[2]) begin
      code_d = 2'b10;
    end else if (req[1]) begin
      code_d = 2'b01;
    end

    valid_d  = |req;
    ones_cnt = {2'b00, req[0]} + {2'b00, req[1]} + {2'b00, req[2]} + {2'b00, req[3]};
    // The code still follows priority when more than one line is asserted.
    err_d    = (ones_cnt >= 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= 2'b00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign y1    = code_q[1];
  assign y0    = code_q[0];
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_encoder_4_2_bh.sv
// Directed bench for encoder_4_2_bh: expected results are queued on drive and
// popped and compared one edge later.
module tb_encoder_4_2_bh;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i3 = 1'b0;
  logic i2 = 1'b0;
  logic i1 = 1'b0;
  logic i0 = 1'b0;
  logic y1;
  logic y0;
  logic valid;
  logic err;

  int checks = 0;
  int failures = 0;

  // Each entry is {y1, y0, valid, err}.
  logic [3:0] exp_q[$];
  logic [3:0] last_exp = 4'b0000;

  always #5 clk = ~clk;

  encoder_4_2_bh dut (
    .clk   (clk),
    .rst   (rst),
    .i3    (i3),
    .i2    (i2),
    .i1    (i1),
    .i0    (i0),
    .y1    (y1),
    .y0    (y0),
    .valid (valid),
    .err   (err)
  );

  function automatic logic [3:0] model(input logic r, input logic [3:0] in_v);
    logic [1:0] code;
    int         n;
    if (r) return 4'b0000;
    code = 2'b00;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (in_v[k]) begin
        code = k[1:0];
        n++;
      end
    end
    return {code, (n > 0), (n > 1)};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive one input set, clock it in, and compare the registered result.
  task automatic step(input string tag, input logic r, input logic [3:0] in_v);
    logic [3:0] expv;
    rst = r;
    {i3, i2, i1, i0} = in_v;
    exp_q.push_back(model(r, in_v));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      expv = exp_q.pop_front();
      last_exp = expv;
      $display("step %-10s rst=%b in=%b out=%b%b valid=%b err=%b", tag, r, in_v, y1, y0, valid, err);
      check({tag, "_code"}, {2'b00, y1, y0}, {2'b00, expv[3:2]});
      check({tag, "_valid"}, {3'b000, valid}, {3'b000, expv[1]});
      check({tag, "_err"}, {3'b000, err}, {3'b000, expv[0]});
    end
  endtask

  initial begin
    logic [3:0] rv;
    @(negedge clk);

    step("reset0", 1'b1, 4'b1111);
    step("reset1", 1'b1, 4'b1111);

    step("oh0001", 1'b0, 4'b0001);
    step("oh0010", 1'b0, 4'b0010);
    step("oh0100", 1'b0, 4'b0100);
    step("oh1000", 1'b0, 4'b1000);

    step("pri0110", 1'b0, 4'b0110);
    step("pri1111", 1'b0, 4'b1111);
    step("pri0011", 1'b0, 4'b0011);
    step("pri0101", 1'b0, 4'b0101);
    step("idle", 1'b0, 4'b0000);

    // Latency: an input change must not reach the outputs before the next edge.
    step("lat0001", 1'b0, 4'b0001);
    {i3, i2, i1, i0} = 4'b1000;
    #2;
    check("lat_hold", {y1, y0, valid, err}, last_exp);
    step("lat1000", 1'b0, 4'b1000);

    step("mid0100", 1'b0, 4'b0100);
    step("midrst", 1'b1, 4'b1000);
    step("midpost", 1'b0, 4'b1000);

    for (int n = 0; n < 24; n++) begin
      rv = 4'($urandom_range(0, 15));
      step("rand", (n == 13), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_4_2_bh.md
ENCODER_4_2_BH -- requirements
Module: encoder_4_2_bh

Interface
REQ-001 Parameters: none; the block SHALL be fixed at 4 inputs, 2-bit code.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i3  input  1  request line 3 (highest priority).
REQ-005 i2  input  1  request line 2.
REQ-006 i1  input  1  request line 1.
REQ-007 i0  input  1  request line 0 (lowest priority).
REQ-008 y1  output  1  encoded index, MSB.
REQ-009 y0  output  1  encoded index, LSB.
REQ-010 valid  output  1  high when the sampled input had at least one line asserted.
REQ-011 err  output  1  high when the sampled input had more than one line asserted (not one-hot).

Function
REQ-012 The block SHALL sample {i3,i2,i1,i0} on every rising clk edge with rst low and drive y1, y0, valid, err from registers; latency one cycle, no combinational input-to-output path.
REQ-013 One-hot encoding SHALL be: 0001->00, 0010->01, 0100->10, 1000->11.
REQ-014 Non-one-hot inputs SHALL resolve by priority, highest asserted index wins: i3 -> 11, else i2 -> 10, else i1 -> 01, else i0 -> 00.
REQ-015 All-zero input SHALL register {y1,y0}=00, valid=0, err=0.
REQ-016 valid SHALL equal OR of the four sampled inputs.
REQ-017 err SHALL be 1 exactly when two or more sampled inputs are 1; {y1,y0} still follows REQ-014 in that case.
REQ-018 Outputs SHALL hold their last registered value between edges; input changes are visible only after the next rising edge.
REQ-019 Back-to-back input changes on consecutive cycles SHALL each produce the corresponding output one cycle later, with no skipped or merged codes.
REQ-020 X/Z inputs are outside the contract; the block need not define outputs for them.

Reset
REQ-021 When rst is high at a rising clk edge, y1, y0, valid, err SHALL all register 0, regardless of inputs.
REQ-022 rst SHALL take priority over input sampling on the same edge.
REQ-023 The first edge with rst low SHALL sample inputs normally (output valid one cycle after rst deasserts).
REQ-024 Reset asserted mid-stream SHALL clear outputs on that edge; no prior input state is retained.

Verification
REQ-025 Reset: rst=1 for 2 cycles with inputs 1111 -> y1y0=00, valid=0, err=0.
REQ-026 One-hot sweep: inputs 0001, 0010, 0100, 1000 on successive cycles -> y1y0 = 00, 01, 10, 11 one cycle later each, valid=1, err=0.
REQ-027 Priority: inputs 0110 -> y1y0=10, valid=1, err=1; 1111 -> 11, valid=1, err=1; 0011 -> 01, err=1.
REQ-028 Idle: inputs 0000 -> y1y0=00, valid=0, err=0.
REQ-029 Latency: change input 0001->1000 -> outputs read 00 in the same cycle and 11 only after the next rising edge.
REQ-030 Mid-stream reset: stream 0100 then assert rst for one edge with input 1000 -> outputs 00/0/0 that cycle, then 11 with valid=1 on the following edge.
